// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_if
// Brief    : Operation request/result bundle for serial_add_sub; ovf exists only
//            when SERIAL_ADD_SUB_OVERFLOW_EN is defined.
// Revision : 1.0
// ============================================================================
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic             ovf;

    modport master (output start, op, a, b, input busy, done, result, cout, ovf);
    modport slave  (input start, op, a, b, output busy, done, result, cout, ovf);
`else
    modport master (output start, op, a, b, input busy, done, result, cout);
    modport slave  (input start, op, a, b, output busy, done, result, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Brief    : Bit-serial adder/subtractor, LSB first, one bit per clock.
//            Optional signed-overflow flag via SERIAL_ADD_SUB_OVERFLOW_EN.
// Revision : 1.0
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_add_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             op_sub;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             bit_val;
    logic             carry_next;
    logic             accept;

    // Start is honoured only outside RUN; a new start in DONE chains straight back.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_comb begin
        bit_val    = opa[0] ^ opb[0] ^ carry;
        carry_next = 1'b0;
        if (!op_sub)
            carry_next = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
        else
            carry_next = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            op_sub   <= 1'b0;
            carry    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state  <= RUN;
                busy_q <= 1'b1;
                opa    <= bus.a;
                opb    <= bus.b;
                op_sub <= bus.op;
                carry  <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    RUN: begin
                        opa      <= opa >> 1;
                        opb      <= opb >> 1;
                        result_q <= {bit_val, result_q[WIDTH-1:1]};
                        carry    <= carry_next;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            // Signed overflow: carry into MSB differs from carry out of it.
                            ovf_q  <= carry ^ carry_next;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = carry;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    assign bus.ovf    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Brief    : Directed self-checking bench for serial_add_sub (WIDTH = 8).
// Revision : 1.0
// ============================================================================
module tb_serial_add_sub;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_add_sub_if #(.WIDTH(8)) bus ();

    serial_add_sub #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one operation; inj > 0 re-pulses start (with other operands) at that RUN cycle.
    task automatic run_op(input string tag, input logic o, input logic [7:0] ai,
                          input logic [7:0] bi, input logic [7:0] er, input logic ec,
                          input logic eovf, input int inj);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = ai;
        bus.b     = bi;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (inj != 0 && i == inj - 1) begin
                bus.start = 1'b1;
                bus.op    = ~o;
                bus.a     = 8'h11;
                bus.b     = 8'h22;
            end else begin
                bus.start = 1'b0;
            end
            chk($sformatf("%s_busy_c%0d", tag, i + 1), {31'd0, bus.busy}, 32'd1);
            chk($sformatf("%s_done_c%0d", tag, i + 1), {31'd0, bus.done}, 32'd0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_result"}, {24'd0, bus.result}, {24'd0, er});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eovf});
`else
        chk($sformatf("%s_idle_ovf%0b", tag, eovf), {31'd0, bus.busy}, 32'd0);
`endif
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_result_hold"}, {24'd0, bus.result}, {24'd0, er});
        chk({tag, "_cout_hold"}, {31'd0, bus.cout}, {31'd0, ec});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        #1;
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_done",   {31'd0, bus.done},   32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_cout",   {31'd0, bus.cout},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_3c_42", 1'b0, 8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0, 0);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 0);
        run_op("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 0);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
        run_op("ign_start", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);

        // Reset in the middle of RUN cycle 4, away from any clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("mid_rst_done",   {31'd0, bus.done},   32'd0);
        chk("mid_rst_result", {24'd0, bus.result}, 32'd0);
        chk("mid_rst_cout",   {31'd0, bus.cout},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("no_done_%0d", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("no_busy_%0d", i), {31'd0, bus.busy}, 32'd0);
        end
        run_op("sub_a5_5a", 1'b1, 8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL have ports a, b  input  WIDTH  operands, sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have port result  output  WIDTH  sum or difference.
REQ-010 SHALL have port cout  output  1  final carry (add) or final borrow (sub).

Function
REQ-011 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; an accepted start latches a, b and op, clears the carry/borrow flop and the bit counter, and moves to RUN.
REQ-013 SHALL ignore start while in RUN, with no effect on operands, op or progress.
REQ-014 SHALL process one bit per cycle in RUN, LSB first, for exactly WIDTH cycles.
REQ-015 SHALL compute each add bit as sum = a^b^c and c_next = a&b | c&(a^b).
REQ-016 SHALL compute each subtract bit as diff = a^b^bw and bw_next = ~a&b | ~(a^b)&bw.
REQ-017 SHALL shift each result bit into result from the MSB side, so that after WIDTH bits result holds the full word in natural order.
REQ-018 SHALL move RUN->DONE after bit WIDTH-1 and assert done for exactly one cycle in DONE.
REQ-019 SHALL, in DONE, go to RUN on start, otherwise go to IDLE.
REQ-020 SHALL set latency from the start-accept edge to done high at WIDTH+1 edges: done is high after edge WIDTH+1.
REQ-021 SHALL assert busy exactly while in RUN.
REQ-022 SHALL hold result and cout stable from DONE until the next accepted start.
REQ-023 SHALL wrap results modulo 2^WIDTH; the lost carry or borrow appears on cout only.

Reset
REQ-024 SHALL, on rst high, immediately force state IDLE, busy=0, done=0, result=0, cout=0, counter=0, and clear latched operands (and ovf=0 when present), independent of clk.
REQ-025 SHALL abandon any in-flight operation when reset is asserted mid-RUN and produce no done pulse for it.
REQ-026 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro SERIAL_ADD_SUB_OVERFLOW_EN is defined, add output ovf (1 bit) that is valid and held like cout and is set to the two's-complement signed overflow of the operation: carry into MSB XOR carry/borrow out of MSB.
REQ-028 SHALL, when SERIAL_ADD_SUB_OVERFLOW_EN is undefined, have no ovf port, with all other behaviour identical.

Verification
REQ-029 Bench SHALL cover WIDTH=8, op=0, a=0x3C, b=0x42, start one cycle -> busy high 8 cycles, done pulse one cycle after edge 9, result=0x7E, cout=0.
REQ-030 Bench SHALL cover op=0, a=0xFF, b=0x01 -> result=0x00, cout=1, and ovf=0 when enabled.
REQ-031 Bench SHALL cover op=1, a=0x05, b=0x07 -> result=0xFE, cout=1. It SHALL also cover op=1, a=0x07, b=0x05 -> result=0x02, cout=0.
REQ-032 Bench SHALL cover start pulsed again at RUN cycle 3 with different a and b -> ignored; the original result is returned at the original done time.
REQ-033 Bench SHALL cover rst asserted at RUN cycle 4, between clock edges -> outputs zero immediately, no done pulse, and the next start completes correctly.
REQ-034 Bench SHALL cover SERIAL_ADD_SUB_OVERFLOW_EN defined, op=0, a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1; op=1, a=0x80, b=0x01 -> result=0x7F, ovf=1.
